// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder arbiter: requester IDs, adder pipeline
// depth, the {valid,id} tag record and the statistics counter helpers used
// when ARB_STATS_EN is defined.
package adder_arbiter_pkg;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  localparam int ADDER_LATENCY = 2;

  localparam int         STAT_W   = 8;
  localparam logic [7:0] STAT_MAX = 8'd255;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  // Saturating increment for the statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    if (v == STAT_MAX) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/adder_arbiter_tag_pipe.sv
// LATENCY-deep shift register of {valid,id} tags that follows each operation
// through the shared adder, so the result can be steered back to its owner.
module adder_arbiter_tag_pipe
  import adder_arbiter_pkg::*;
#(
  parameter int LATENCY = ADDER_LATENCY
) (
  input  logic clk,
  input  logic clr,
  input  tag_t head,
  output tag_t tail
);

  tag_t pipe_r [LATENCY];

  // Shift tags one stage per clock; clear drops every in-flight tag.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_r[i] <= '{valid: 1'b0, id: 1'b0};
      end
    end else begin
      pipe_r[0] <= head;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign tail = pipe_r[LATENCY-1];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one pipelined adder between two requesters.
// Grants are combinational, the granted operands go straight to the adder,
// and a tag pipe matched to the adder latency routes each result back as a
// one-cycle Vld strobe. Define ARB_STATS_EN to add grant/conflict counters.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int LATENCY = ADDER_LATENCY,
  parameter int W       = 2
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Req0,
  input  logic [W-1:0] A0,
  input  logic [W-1:0] B0,
  output logic         Gnt0,
  input  logic         Req1,
  input  logic [W-1:0] A1,
  input  logic [W-1:0] B1,
  output logic         Gnt1,
  output logic [W-1:0] Add_A,
  output logic [W-1:0] Add_B,
  input  logic [W-1:0] Add_Sum,
  input  logic         Add_Carry,
  output logic         Vld0,
  output logic         Vld1,
  output logic [W-1:0] Res_Sum,
  output logic         Res_Carry
`ifdef ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] Cnt0,
  output logic [STAT_W-1:0] Cnt1,
  output logic [STAT_W-1:0] Conflicts
`endif
);

  logic gnt0_s;
  logic gnt1_s;
  logic grant_any_s;
  logic rr_last_r;
  tag_t head_s;
  tag_t tail_s;

  // Grant selection: lone requester wins, contention goes to the one that
  // was not granted last; nothing is granted while in reset.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (Rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (Req0 && Req1) begin
      if (rr_last_r == ID_REQ1) begin
        gnt0_s = 1'b1;
      end else begin
        gnt1_s = 1'b1;
      end
    end else if (Req0) begin
      gnt0_s = 1'b1;
    end else if (Req1) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  assign grant_any_s = gnt0_s | gnt1_s;
  assign Gnt0        = gnt0_s;
  assign Gnt1        = gnt1_s;

  // Operand mux: the granted requester's operands, zero when idle.
  always_comb begin
    Add_A = '0;
    Add_B = '0;
    case ({gnt1_s, gnt0_s})
      2'b01: begin
        Add_A = A0;
        Add_B = B0;
      end
      2'b10: begin
        Add_A = A1;
        Add_B = B1;
      end
      default: begin
        Add_A = '0;
        Add_B = '0;
      end
    endcase
  end

  // Remember the last granted ID; idle cycles keep the previous winner.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rr_last_r <= ID_REQ1;
    end else if (grant_any_s) begin
      rr_last_r <= gnt1_s ? ID_REQ1 : ID_REQ0;
    end else begin
      rr_last_r <= rr_last_r;
    end
  end

  assign head_s = '{valid: grant_any_s, id: gnt1_s};

  adder_arbiter_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_tag_pipe (
    .clk  (Clk),
    .clr  (Rst),
    .head (head_s),
    .tail (tail_s)
  );

  // Result demux: the retiring tag selects which requester sees the strobe.
  assign Vld0      = !Rst && tail_s.valid && (tail_s.id == ID_REQ0);
  assign Vld1      = !Rst && tail_s.valid && (tail_s.id == ID_REQ1);
  assign Res_Sum   = Add_Sum;
  assign Res_Carry = Add_Carry;

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] cnt0_r;
  logic [STAT_W-1:0] cnt1_r;
  logic [STAT_W-1:0] conflicts_r;

  // Saturating per-requester grant counts and contention count.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt0_r      <= 8'd0;
      cnt1_r      <= 8'd0;
      conflicts_r <= 8'd0;
    end else begin
      cnt0_r      <= gnt0_s ? sat_inc(cnt0_r) : cnt0_r;
      cnt1_r      <= gnt1_s ? sat_inc(cnt1_r) : cnt1_r;
      conflicts_r <= (Req0 && Req1) ? sat_inc(conflicts_r) : conflicts_r;
    end
  end

  assign Cnt0      = cnt0_r;
  assign Cnt1      = cnt1_r;
  assign Conflicts = conflicts_r;
`endif

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Round-robin arbiter sharing one adder_synchronous instance (2-bit operands, registered in and out, 2-cycle latency) between two requesters.
- Issues at most one operation per clock and tracks an ID tag through the adder pipeline.
- Steers each result back to its originator with a one-cycle valid strobe.
- Sits between two client FSMs and the shared adder instance at the next level up.

Parameters:
- LATENCY, 2, clock edges from operand capture at adder input to result on Add_Sum/Add_Carry; must match the adder's pipeline depth.
- W, 2, operand width.

Ports:
- Clk  input  1  system clock; all state updates on posedge.
- Rst  input  1  synchronous, active-high reset.
- Req0  input  1  requester 0 operation request.
- A0, B0  input  W each  requester 0 operands.
- Gnt0  output  1  requester 0 granted this cycle.
- Req1  input  1  requester 1 operation request.
- A1, B1  input  W each  requester 1 operands.
- Gnt1  output  1  requester 1 granted this cycle.
- Add_A, Add_B  output  W each  operands to the shared adder.
- Add_Sum  input  W  sum from the shared adder.
- Add_Carry  input  1  carry from the shared adder.
- Vld0, Vld1  output  1 each  result valid for requester 0 / 1.
- Res_Sum  output  W  result sum, common to both requesters.
- Res_Carry  output  1  result carry, common to both requesters.

Behaviour:
- Interface: one clock (Clk). Reset (Rst) is synchronous and active-high.
- Reset values: Vld0=Vld1=0; tag pipe all invalid; rr_last=1, so requester 0 wins the first contention. Gnt0=Gnt1=0 while Rst=1. Add_A=Add_B=0 while no grant.
- Grant logic is combinational from Req0/Req1/rr_last. Gnt0 and Gnt1 are one-hot or zero.
  - Only Req0 high -> Gnt0. Only Req1 high -> Gnt1.
  - Both high -> grant the requester not equal to rr_last.
- rr_last updates at posedge to the granted ID, only on cycles with a grant. Idle cycles leave it unchanged.
- Granted operands drive Add_A/Add_B combinationally in the same cycle; the adder captures them at that posedge.
- Handshake:
  - A requester holds Req and operands stable until it samples Gnt=1 at a posedge.
  - A transfer is complete on that edge.
  - Req may drop before a grant without side effect.
  - Back-to-back requests from one ID are allowed; one transfer per grant.
- Tag pipe: LATENCY-deep shift register of {valid, id}. The head is loaded each posedge with {grant_any, granted_id}.
- Result path:
  - When the tail is valid, Vld[id]=1 for exactly one cycle.
  - Res_Sum=Add_Sum and Res_Carry=Add_Carry, combinational pass-through.
  - A result for a grant at edge n is valid in the cycle after edge n+LATENCY-1, i.e. 2 cycles after the grant cycle for LATENCY=2.
- No result backpressure; requesters must accept Vld when it arrives.
- Throughput: one operation per cycle. Full pipelining; no bubbles inserted.
- Arithmetic is done entirely by the adder. The arbiter adds no width change: Res_Sum is W bits and Res_Carry is the carry out.
- Reset mid-operation: the tag pipe clears, so in-flight adder results emerging after reset produce no Vld.
- Simultaneous events: a grant and a retiring result in the same cycle are independent. A requester may be granted while its own earlier result is retiring.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds outputs Cnt0 and Cnt1, 8 bits each.
  - Each increments on its requester's grant and saturates at 255.
  - Adds output Conflicts, 8 bits, saturating; increments on cycles with Req0&Req1.
  - All three counters reset to 0.
- Undefined: none of these ports or registers exist. Functional behaviour is otherwise identical.

Decomposition:
- Shared header arb_defs.vh holds:
  - ID_REQ0=0 and ID_REQ1=1.
  - ADDER_LATENCY=2.
  - Stats counter width 8 and saturation value 255.
- Sub-module arb_tag_pipe: parameterised LATENCY-deep {valid,id} shift register with synchronous clear. Instantiated once.
- Top level holds the grant logic, rr_last, operand mux and result demux.

Test Plan:
- Reset then Req0=1, A0=2'b11, B0=2'b01 held one cycle -> Gnt0=1 in that cycle; 2 cycles later Vld0=1, Res_Sum=2'b00, Res_Carry=1; Vld1 stays 0.
- Req0 and Req1 both high for 4 cycles (A0=1,B0=1; A1=2,B1=1) -> grants alternate 0,1,0,1; Vld alternates 0,1,0,1 two cycles later with sums 2,3,2,3.
- Only Req1 high for 3 cycles -> Gnt1 all three cycles. On the next contention, requester 0 wins.
- Grant issued, then Rst pulsed one cycle before the result would retire -> no Vld0/Vld1 for that operation; the first post-reset contention grants requester 0.
- Req0 asserted then dropped before any grant (Req1 held high) -> no Gnt0, no Vld0; rr_last unaffected by the dropped request.
- With ARB_STATS_EN: 10 cycles of both requesting -> Cnt0=5, Cnt1=5, Conflicts=10. Run 300 single-requester grants -> Cnt0 saturates at 255.
